// File: rtl/dino_game_engine.sv
// rtl/dino_game_engine.sv - dino game FSM, jump physics, obstacle channels, collision, score and speed ramp
// One game step per tick; gamedata packs the player in slot 0 and obstacles in slots 1..NUM_OBST.
module dino_game_engine #(
  parameter int NUM_OBST       = 2,
  parameter int SCREEN_W       = 160,
  parameter int GROUND_Y       = 100,
  parameter int PLAYER_X       = 16,
  parameter int JUMP_V         = 12,
  parameter int GRAVITY        = 1,
  parameter int HIT_W          = 8,
  parameter int HIT_H          = 8,
  parameter int OBST_GAP       = 64,
  parameter int SPEED_INIT     = 1,
  parameter int SPEED_MAX      = 4,
  parameter int SPEED_STEP_PTS = 100,
  parameter int SCORE_W        = 16
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       jump,
  output logic [16*(NUM_OBST+1)-1:0] gamedata,
  output logic [SCORE_W-1:0]         score,
  output logic [1:0]                 state,
  output logic                       game_over
);

  localparam int IW = (NUM_OBST > 1) ? $clog2(NUM_OBST) : 1;
  localparam logic [7:0]         X_SPAWN   = 8'(SCREEN_W - 1);
  localparam logic [7:0]         X_GAP_MAX = 8'(SCREEN_W - 1 - OBST_GAP);
  localparam logic [7:0]         X_PLAYER  = 8'(PLAYER_X);
  localparam logic [7:0]         HIT_W8    = 8'(HIT_W);
  localparam logic [6:0]         HIT_H7    = 7'(HIT_H);
  localparam logic [6:0]         Y_GROUND  = 7'(GROUND_Y);
  localparam logic signed [7:0]  V_JUMP    = 8'(JUMP_V);
  localparam logic signed [7:0]  V_GRAV    = 8'(GRAVITY);
  localparam logic [7:0]         SPD_INIT  = 8'(SPEED_INIT);
  localparam logic [7:0]         SPD_MAX   = 8'(SPEED_MAX);
  localparam logic [15:0]        STEP_LAST = 16'(SPEED_STEP_PTS - 1);
  localparam logic [SCORE_W-1:0] SCORE_SAT = '1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_OVER = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                jump_prev, jump_pending, pend_d;
  logic [7:0]          lfsr, lfsr_d;
  logic [6:0]          h, h_d;
  logic signed [7:0]   v, v_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [7:0]          speed, speed_d;
  logic [15:0]         step_cnt, step_d;
  logic [NUM_OBST-1:0] ob_valid, ob_valid_d;
  logic [7:0]          ob_x   [NUM_OBST];
  logic [7:0]          ob_x_d [NUM_OBST];
  logic [IW-1:0]       newest, newest_d, free_idx;
  logic                have_free, gap_ok, hit, collide, jump_edge, req, land;
  logic signed [8:0]   hv;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  assign jump_edge = jump & ~jump_prev;
  assign req       = jump_pending | jump_edge;
  assign hv        = $signed({2'b00, h}) + $signed({v[7], v});
  assign land      = (hv <= 9'sd0);

  always_comb begin
    hit       = 1'b0;
    have_free = 1'b0;
    free_idx  = '0;
    for (int c = NUM_OBST - 1; c >= 0; c--) begin
      if (ob_valid[c] && (abs_diff(ob_x[c], X_PLAYER) < HIT_W8)) hit = 1'b1;
      if (!ob_valid[c]) begin
        have_free = 1'b1;
        free_idx  = IW'(c);
      end
    end
    collide = hit && (h < HIT_H7);
    gap_ok  = !(|ob_valid) || !ob_valid[newest] || (ob_x[newest] <= X_GAP_MAX);
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr;
    pend_d     = tick ? 1'b0 : (jump_pending | jump_edge);
    h_d        = h;
    v_d        = v;
    score_d    = score_q;
    speed_d    = speed;
    step_d     = step_cnt;
    ob_valid_d = ob_valid;
    ob_x_d     = ob_x;
    newest_d   = newest;
    if (tick) begin
      lfsr_d = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
      case (state_q)
        ST_IDLE: if (req) begin
          state_d    = ST_RUN;
          score_d    = '0;
          ob_valid_d = '0;
          ob_x_d     = '{default: '0};
          newest_d   = '0;
          h_d        = '0;
          v_d        = '0;
          step_d     = '0;
          speed_d    = SPD_INIT;
        end
        ST_RUN: if (collide) begin
          state_d = ST_OVER;
        end else begin
          // A jump is only taken from rest on the ground; requests in the air are dropped.
          if (h == 7'd0 && v == 8'sd0) begin
            if (req) v_d = V_JUMP;
          end else if (land) begin
            h_d = '0;
            v_d = '0;
          end else begin
            h_d = hv[6:0];
            v_d = v - V_GRAV;
          end
          for (int c = 0; c < NUM_OBST; c++) begin
            if (ob_valid[c]) begin
              if (ob_x[c] < speed) begin
                ob_valid_d[c] = 1'b0;
                ob_x_d[c]     = '0;
              end else begin
                ob_x_d[c] = ob_x[c] - speed;
              end
            end
          end
          if (lfsr[2:0] == 3'd0 && gap_ok && have_free) begin
            ob_valid_d[free_idx] = 1'b1;
            ob_x_d[free_idx]     = X_SPAWN;
            newest_d             = free_idx;
          end
          if (score_q != SCORE_SAT) score_d = score_q + 1'b1;
          if (step_cnt == STEP_LAST) begin
            step_d = '0;
            if (speed < SPD_MAX) speed_d = speed + 8'd1;
          end else begin
            step_d = step_cnt + 16'd1;
          end
        end
        ST_OVER: if (req) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      jump_prev    <= 1'b0;
      jump_pending <= 1'b0;
      lfsr         <= 8'hA5;
      h            <= '0;
      v            <= '0;
      score_q      <= '0;
      speed        <= SPD_INIT;
      step_cnt     <= '0;
      ob_valid     <= '0;
      ob_x         <= '{default: '0};
      newest       <= '0;
    end else begin
      state_q      <= state_d;
      jump_prev    <= jump;
      jump_pending <= pend_d;
      lfsr         <= lfsr_d;
      h            <= h_d;
      v            <= v_d;
      score_q      <= score_d;
      speed        <= speed_d;
      step_cnt     <= step_d;
      ob_valid     <= ob_valid_d;
      ob_x         <= ob_x_d;
      newest       <= newest_d;
    end
  end

  always_comb begin
    gamedata        = '0;
    gamedata[15:0]  = {1'b1, Y_GROUND - h, X_PLAYER};
    for (int c = 0; c < NUM_OBST; c++)
      gamedata[16*(c+1) +: 16] = {ob_valid[c], (ob_valid[c] ? Y_GROUND : 7'd0), ob_x[c]};
  end

  assign score     = score_q;
  assign state     = state_q;
  assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_dino_game_engine.sv
// tb/tb_dino_game_engine.sv - directed bench for dino_game_engine
// dut_nc has a closed hit window so its long run never collides.
module tb_dino_game_engine;
  logic        clock = 1'b0, rst = 1'b0, tick = 1'b0, jump = 1'b0;
  logic [47:0] gamedata, gd_nc, prev;
  logic [15:0] score, score_nc;
  logic [1:0]  state, state_nc;
  logic        game_over, go_nc;
  int total = 0, bad = 0, ticks = 0, e_tick = 0, spawn_i = 0, c_i = 0, k = 0, spd = 0;
  logic spawn_seen = 1'b0;

  always #5 clock = ~clock;

  dino_game_engine dut (
    .clock(clock), .rst(rst), .tick(tick), .jump(jump),
    .gamedata(gamedata), .score(score), .state(state), .game_over(game_over));

  dino_game_engine #(.HIT_W(0)) dut_nc (
    .clock(clock), .rst(rst), .tick(tick), .jump(jump),
    .gamedata(gd_nc), .score(score_nc), .state(state_nc), .game_over(go_nc));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic jump_pulse();
    @(negedge clock) jump = 1'b1;
    @(negedge clock) jump = 1'b0;
  endtask

  task automatic do_tick(input logic with_jump);
    @(negedge clock);
    tick = 1'b1;
    if (with_jump) jump = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    jump = 1'b0;
    ticks++;
    if (!spawn_seen && (gamedata[31] || gamedata[47])) begin
      spawn_seen = 1'b1;
      spawn_i    = ticks - e_tick;
      check_eq("first_spawn", gamedata[31:16], 16'hE49F);
    end
  endtask

  function automatic int spd_at(input int i);
    int s;
    s = 1 + (i - 1) / 100;
    return (s > 4) ? 4 : s;
  endfunction

  // RUN tick index at which an obstacle spawned during RUN tick s_i sits in 9..23
  function automatic int collide_idx(input int s_i);
    int x, i;
    x = 159;
    i = s_i + 1;
    while (!(x >= 9 && x <= 23) && i < s_i + 1000) begin
      x = x - spd_at(i);
      i++;
    end
    return i;
  endfunction

  initial begin
    repeat (3) @(negedge clock);
    rst = 1'b1;
    check_eq("rst_state", state, 0);
    check_eq("rst_gamedata", gamedata, 48'h0000_0000_E410);

    repeat (5) do_tick(1'b0);
    check_eq("idle_state", state, 0);
    check_eq("idle_score", score, 0);
    check_eq("idle_over", game_over, 0);
    check_eq("idle_gamedata", gamedata, 48'h0000_0000_E410);
    check_eq("idle_gamedata_nc", gd_nc, 48'h0000_0000_E410);

    jump_pulse();
    do_tick(1'b0);
    e_tick = ticks;
    spawn_seen = 1'b0;
    check_eq("enter_run", state, 1);
    check_eq("enter_score", score, 0);
    jump_pulse();
    do_tick(1'b0);
    check_eq("jump_t0_y", gamedata[14:8], 100);
    for (int j = 1; j <= 27; j++) begin
      if (j == 5) jump_pulse();
      do_tick(1'b0);
      case (j)
        1:  check_eq("jump_t1_y", gamedata[14:8], 88);
        2:  check_eq("jump_t2_y", gamedata[14:8], 77);
        12: check_eq("jump_t12_y", gamedata[14:8], 22);
        13: check_eq("jump_t13_y", gamedata[14:8], 22);
        24: check_eq("jump_t24_y", gamedata[14:8], 88);
        25: begin
          check_eq("jump_t25_y", gamedata[14:8], 100);
          check_eq("jump_t25_score", score, 26);
        end
        27: check_eq("jump_t27_y", gamedata[14:8], 100);
        default: ;
      endcase
    end

    k = 0;
    while (!spawn_seen && k < 400) begin do_tick(1'b0); k++; end
    check_eq("spawn_seen", spawn_seen, 1);
    c_i = collide_idx(spawn_i);
    while ((ticks - e_tick) < (c_i - 1) && k < 1500) begin do_tick(1'b0); k++; end
    check_eq("run_before_hit", state, 1);
    do_tick(1'b0);
    check_eq("over_at_hit", state, 2);
    check_eq("over_flag", game_over, 1);
    check_eq("score_at_hit", score, c_i - 1);
    repeat (3) do_tick(1'b0);
    check_eq("over_frozen_state", state, 2);
    check_eq("over_frozen_score", score, c_i - 1);
    jump_pulse();
    do_tick(1'b0);
    check_eq("over_to_idle", state, 0);
    check_eq("idle_flag", game_over, 0);
    jump_pulse();
    do_tick(1'b0);
    e_tick = ticks;
    spawn_seen = 1'b0;
    check_eq("rerun_state", state, 1);
    check_eq("rerun_score", score, 0);
    check_eq("rerun_obst", gamedata[47:16], 0);

    k = 0;
    while (!spawn_seen && k < 400) begin do_tick(1'b0); k++; end
    c_i = collide_idx(spawn_i);
    while ((ticks - e_tick) < (c_i - 1) && k < 1500) begin do_tick(1'b0); k++; end
    do_tick(1'b1);
    check_eq("jump_hit_state", state, 2);
    check_eq("jump_hit_v", dut.v, 0);
    check_eq("jump_hit_y", gamedata[14:8], 100);
    check_eq("jump_hit_score", score, c_i - 1);
    do_tick(1'b0);
    check_eq("jump_hit_consumed", state, 2);
    @(negedge clock);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_gamedata", gamedata, 48'h0000_0000_E410);
    check_eq("async_rst_state", state, 0);
    check_eq("async_rst_score", score, 0);
    check_eq("async_rst_over", game_over, 0);
    @(negedge clock) rst = 1'b1;

    jump_pulse();
    do_tick(1'b0);
    check_eq("nc_enter_run", state_nc, 1);
    for (int i = 1; i <= 400; i++) begin
      prev = gd_nc;
      spd = spd_at(i);
      do_tick(1'b0);
      for (int c = 0; c < 2; c++) begin
        if (prev[16*c+31]) begin
          if (int'(prev[16*c+16 +: 8]) < spd)
            check_eq("obst_expire", gd_nc[16*c+31], 0);
          else
            check_eq("obst_move", {gd_nc[16*c+31], gd_nc[16*c+16 +: 8]},
                     {1'b1, 8'(int'(prev[16*c+16 +: 8]) - spd)});
        end else if (gd_nc[16*c+31]) begin
          check_eq("spawn_slot", gd_nc[16*c+16 +: 16], 16'hE49F);
          if (prev[16*(1-c)+31])
            check_eq("spawn_gap", (prev[16*(1-c)+16 +: 8] > 8'd95), 0);
        end
      end
      if (i % 100 == 0) begin
        check_eq("ramp_speed", dut_nc.speed, spd_at(i + 1));
        check_eq("ramp_score", score_nc, i);
      end
    end
    check_eq("ramp_state", state_nc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
